eth_wb_reg_slave: RTL
=====================

Name: eth_wb_reg_slave

Overview:
Wishbone classic slave that implements the Ethernet MAC control/status register file at the MAC register offsets 0x00-0x50. It is the responder to the testbench and host Wishbone initiator. It drives the configuration fields to the MAC core, collects interrupt events into a write-1-to-clear source register, and raises a masked interrupt. MII command bits are issued as single-cycle pulses.

Parameters:
ADR_W, 8, byte-address width; bits [1:0] are ignored.
TX_BD_MAX, 8'h80, maximum legal TX_BD_NUM value.

Ports:
wb_clk_i  in  1  single clock
wb_rst_ni  in  1  asynchronous active-low reset
wb_adr_i  in  ADR_W  byte address (register offset)
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte lane enables
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle valid
wb_dat_o  out  32  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination (unmapped offset)
irq_event_i  in  7  event pulses {rxc,txc,busy,rxe,rxb,txe,txb}
mii_rx_data_i  in  16  MII read data (MIIRX_DATA)
mii_status_i  in  3  {nvalid,busy,linkfail}
int_o  out  1  interrupt request
moder_o  out  17  MODER[16:0]
tx_bd_num_o  out  8  TX_BD_NUM
mac_addr_o  out  48  {MAC_ADDR1[15:0],MAC_ADDR0}
ipgt_o  out  7  IPGT[6:0]
packetlen_o  out  32  {minfl,maxfl}
collconf_o  out  32  COLLCONF
mii_cmd_o  out  3  {wctrldata,rstat,scanstat} pulses

Behaviour:
- Access: `req = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o)`. The response is registered, so ack or err rises the cycle after req and lasts exactly 1 cycle. A held stb therefore gets 1 response every 2 cycles. ack and err are never both high.
- Decode: wb_adr_i[ADR_W-1:2] selects 0x00..0x50. Any other offset gives err=1, writes have no effect and read data is 0.
- Writes take effect on the req edge and honour wb_sel_i per byte. Reads return the register value at the req edge in wb_dat_o, valid with ack; wb_dat_o is 0 when ack is low.
- Reset values (all outputs):
  - MODER 0x0000A000
  - INT_SOURCE 0, INT_MASK 0
  - IPGT 0x12, IPGR1 0x0C, IPGR2 0x12
  - PACKETLEN 0x00400600, COLLCONF 0x000F003F
  - TX_BD_NUM 0x40, MIIMODER 0x64
  - all other registers 0
  - ack, err, int_o and mii_cmd_o all 0
- Unimplemented bits read as 0 and ignore writes. Field widths:
  - MODER 17 bits
  - INT_SOURCE/MASK 7
  - IPGT/IPGR1/IPGR2 7
  - COLLCONF bits [21:16] and [5:0]
  - TX_BD_NUM 8
  - CTRLMODER 3, MIIMODER 9, MIICOMMAND 3
  - MIIADDRESS bits [12:8] and [4:0]
  - MIITX_DATA 16, MAC_ADDR1 16, TXCTRL 17
- Read-only registers: MIIRX_DATA and MIISTATUS reflect their inputs. Writes to them are acked and ignored.
- TX_BD_NUM: a write whose resulting value exceeds TX_BD_MAX is acked but not applied.
- INT_SOURCE:
  - A bit sets when irq_event_i is high that cycle.
  - Writing 1 clears the bit; writing 0 has no effect.
  - If a set and a clear land on the same bit in the same cycle, the set wins.
- int_o is registered: `int_o <= |(INT_SOURCE & INT_MASK)`, 1 cycle after the source or mask changes.
- MIICOMMAND:
  - A write with a bit set pulses mii_cmd_o for exactly 1 cycle (the ack cycle).
  - Bits 1 (rstat) and 2 (wctrldata) read back as 0.
  - Bit 0 (scanstat) is stored and reads back as written.
  - While mii_status_i[1] (busy) = 1, MIICOMMAND writes are acked and ignored (no pulse).
- Reset mid-cycle: asynchronous clear of all state. A transaction in flight is dropped with no ack; the master must reissue it.
- wb_cyc_i dropping while stb is high aborts the request; no response is generated.

Decomposition:
- Extend the shared MAC info package with:
  - register offset constants
  - reset-value constants
  - packed typedefs for MODER, INT_MASK and INT_SOURCE, matching the existing field lists
- Both RTL and bench import these.
- One natural sub-module: eth_irq_ctrl. It holds INT_SOURCE/INT_MASK, applies the W1C/set-priority rule and drives int_o.

Test Plan:
1. Reset, then read every offset 0x00-0x50 -> each returns its reset value (MODER 0x0000A000, TX_BD_NUM 0x40, PACKETLEN 0x00400600, …); ack 1 cycle after req; err never asserted.
2. Write MAC_ADDR0=0x11223344 with sel=4'b0101, then read -> 0x00220044; mac_addr_o[31:0] matches.
3. Write TX_BD_NUM=0x81 -> acked, value stays 0x40; write 0x80 -> reads 0x80.
4. Set INT_MASK=0x04; pulse irq_event_i=0x04 -> INT_SOURCE=0x04 and int_o=1 one cycle later. Then write INT_SOURCE=0x04 in the same cycle as another 0x04 event -> bit stays 1. Clear it again with no event -> int_o=0 one cycle after the bit clears.
5. Write MIICOMMAND=0x2 with busy=0 -> mii_cmd_o=3'b010 for 1 cycle, readback 0. Repeat with busy=1 -> no pulse.
6. Access offset 0x54 -> err=1, ack=0, rdata 0. Assert wb_rst_ni low during a pending req -> no ack, all outputs at reset values.

Source files
------------

// File: rtl/eth_wb_reg_slave_pkg.sv
// -----------------------------------------------------------------------------
// eth_wb_reg_slave_pkg
// Shared MAC register-file definitions: register byte offsets, reset values,
// packed field layouts for MODER and the interrupt vectors, and a byte-lane
// merge helper. Imported by the register slave, its interrupt controller and
// the bench.
// -----------------------------------------------------------------------------
package eth_wb_reg_slave_pkg;

    // Register byte offsets (32-bit so they compare directly against a
    // zero-extended bus address).
    localparam logic [31:0] ADR_MODER      = 32'h00;
    localparam logic [31:0] ADR_INT_SOURCE = 32'h04;
    localparam logic [31:0] ADR_INT_MASK   = 32'h08;
    localparam logic [31:0] ADR_IPGT       = 32'h0C;
    localparam logic [31:0] ADR_IPGR1      = 32'h10;
    localparam logic [31:0] ADR_IPGR2      = 32'h14;
    localparam logic [31:0] ADR_PACKETLEN  = 32'h18;
    localparam logic [31:0] ADR_COLLCONF   = 32'h1C;
    localparam logic [31:0] ADR_TX_BD_NUM  = 32'h20;
    localparam logic [31:0] ADR_CTRLMODER  = 32'h24;
    localparam logic [31:0] ADR_MIIMODER   = 32'h28;
    localparam logic [31:0] ADR_MIICOMMAND = 32'h2C;
    localparam logic [31:0] ADR_MIIADDRESS = 32'h30;
    localparam logic [31:0] ADR_MIITX_DATA = 32'h34;
    localparam logic [31:0] ADR_MIIRX_DATA = 32'h38;
    localparam logic [31:0] ADR_MIISTATUS  = 32'h3C;
    localparam logic [31:0] ADR_MAC_ADDR0  = 32'h40;
    localparam logic [31:0] ADR_MAC_ADDR1  = 32'h44;
    localparam logic [31:0] ADR_HASH0      = 32'h48;
    localparam logic [31:0] ADR_HASH1      = 32'h4C;
    localparam logic [31:0] ADR_TXCTRL     = 32'h50;
    localparam logic [31:0] ADR_LAST       = ADR_TXCTRL;

    // Reset values
    localparam logic [16:0] MODER_RST      = 17'h0A000;  // PAD | CRCEN
    localparam logic [6:0]  IPGT_RST       = 7'h12;
    localparam logic [6:0]  IPGR1_RST      = 7'h0C;
    localparam logic [6:0]  IPGR2_RST      = 7'h12;
    localparam logic [31:0] PACKETLEN_RST  = 32'h0040_0600;
    localparam logic [5:0]  COLL_MAX_RST   = 6'h0F;     // COLLCONF[21:16]
    localparam logic [5:0]  COLL_VALID_RST = 6'h3F;     // COLLCONF[5:0]
    localparam logic [7:0]  TX_BD_NUM_RST  = 8'h40;
    localparam logic [8:0]  MIIMODER_RST   = 9'h064;

    typedef struct packed {
        logic recsmall;  // 16
        logic pad;       // 15
        logic hugen;     // 14
        logic crcen;     // 13
        logic dlycrcen;  // 12
        logic rst;       // 11
        logic fulld;     // 10
        logic exdfren;   // 9
        logic nobckof;   // 8
        logic loopbck;   // 7
        logic ifg;       // 6
        logic pro;       // 5
        logic iam;       // 4
        logic bro;       // 3
        logic nopre;     // 2
        logic txen;      // 1
        logic rxen;      // 0
    } moder_t;

    typedef struct packed {
        logic rxc;   // 6
        logic txc;   // 5
        logic busy;  // 4
        logic rxe;   // 3
        logic rxb;   // 2
        logic txe;   // 1
        logic txb;   // 0
    } int_vec_t;

    typedef int_vec_t int_source_t;
    typedef int_vec_t int_mask_t;

    // Merge new write data into an old word, byte lane by byte lane.
    function automatic logic [31:0] byte_wr(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = sel[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/eth_wb_reg_slave_if.sv
// -----------------------------------------------------------------------------
// eth_wb_reg_slave_if
// Wishbone classic bus bundle between a host initiator and the MAC register
// slave.
//   adr/wdat/sel/we/stb/cyc : initiator -> slave
//   rdat/ack/err            : slave -> initiator
// -----------------------------------------------------------------------------
interface eth_wb_reg_slave_if #(
    parameter int ADR_W = 8
);
    logic [ADR_W-1:0] adr;
    logic [31:0]      wdat;
    logic [3:0]       sel;
    logic             we;
    logic             stb;
    logic             cyc;
    logic [31:0]      rdat;
    logic             ack;
    logic             err;

    modport master (output adr, wdat, sel, we, stb, cyc,
                    input  rdat, ack, err);
    modport slave  (input  adr, wdat, sel, we, stb, cyc,
                    output rdat, ack, err);
endinterface

// File: rtl/eth_wb_reg_slave_irq_ctrl.sv
// -----------------------------------------------------------------------------
// eth_irq_ctrl
// Interrupt source/mask registers for the MAC register file.
//   clk_i, rst_ni : clock, async active-low reset
//   event_i       : one-cycle event pulses, OR-ed into the source register
//   src_wr_i      : write-1-to-clear strobe for the source register
//   mask_wr_i     : load strobe for the mask register
//   wdat_i        : write data for either strobe
//   src_o, mask_o : current register contents (for read-back)
//   int_o         : registered OR of enabled pending sources
// -----------------------------------------------------------------------------
module eth_irq_ctrl
    import eth_wb_reg_slave_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  int_vec_t    event_i,
    input  logic        src_wr_i,
    input  logic        mask_wr_i,
    input  logic [6:0]  wdat_i,
    output int_source_t src_o,
    output int_mask_t   mask_o,
    output logic        int_o
);
    logic [6:0] src_q, src_d;
    logic [6:0] mask_q, mask_d;
    logic       int_q;

    always_comb begin
        src_d  = src_q;
        mask_d = mask_q;
        if (src_wr_i)
            src_d = src_d & ~wdat_i;
        // Applied after the clear so a same-cycle event keeps its bit.
        src_d = src_d | event_i;
        if (mask_wr_i)
            mask_d = wdat_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q  <= '0;
            mask_q <= '0;
            int_q  <= 1'b0;
        end else begin
            src_q  <= src_d;
            mask_q <= mask_d;
            int_q  <= |(src_q & mask_q);
        end
    end

    assign src_o  = src_q;
    assign mask_o = mask_q;
    assign int_o  = int_q;

endmodule

// File: rtl/eth_wb_reg_slave.sv
// -----------------------------------------------------------------------------
// eth_wb_reg_slave
// Wishbone classic slave holding the Ethernet MAC control/status registers
// (offsets 0x00-0x50). Responses are registered: ack/err follow a request by
// one cycle and last one cycle.
//   wb_clk_i, wb_rst_ni : clock, async active-low reset
//   wb                  : Wishbone slave bus (eth_wb_reg_slave_if.slave)
//   irq_event_i         : event pulses {rxc,txc,busy,rxe,rxb,txe,txb}
//   mii_rx_data_i       : MII read data, shown at MIIRX_DATA
//   mii_status_i        : {nvalid,busy,linkfail}, shown at MIISTATUS
//   int_o               : masked interrupt request
//   moder_o ... collconf_o : configuration fields to the MAC core
//   mii_cmd_o           : {wctrldata,rstat,scanstat} one-cycle command pulses
// -----------------------------------------------------------------------------
module eth_wb_reg_slave
    import eth_wb_reg_slave_pkg::*;
#(
    parameter int          ADR_W     = 8,
    parameter logic [7:0]  TX_BD_MAX = 8'h80
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    eth_wb_reg_slave_if.slave        wb,
    input  logic [6:0]               irq_event_i,
    input  logic [15:0]              mii_rx_data_i,
    input  logic [2:0]               mii_status_i,
    output logic                     int_o,
    output logic [16:0]              moder_o,
    output logic [7:0]               tx_bd_num_o,
    output logic [47:0]              mac_addr_o,
    output logic [6:0]               ipgt_o,
    output logic [31:0]              packetlen_o,
    output logic [31:0]              collconf_o,
    output logic [2:0]               mii_cmd_o
);
    moder_t      moder_q;
    logic [6:0]  ipgt_q, ipgr1_q, ipgr2_q;
    logic [31:0] packetlen_q;
    logic [5:0]  coll_max_q, coll_valid_q;
    logic [7:0]  tx_bd_num_q;
    logic [2:0]  ctrlmoder_q;
    logic [8:0]  miimoder_q;
    logic        scanstat_q;
    logic [4:0]  rgad_q, fiad_q;
    logic [15:0] miitx_q;
    logic [31:0] mac0_q;
    logic [15:0] mac1_q;
    logic [31:0] hash0_q, hash1_q;
    logic [16:0] txctrl_q;

    logic        ack_q, err_q;
    logic [31:0] rdat_q;
    logic [2:0]  mii_cmd_q;

    int_source_t int_src;
    int_mask_t   int_mask;

    logic [31:0] off;
    logic        req, mapped, wr_en, mii_busy;
    logic [31:0] rd_data, wv;

    // Word-aligned byte offset; the low two address bits are don't-care.
    assign off      = 32'(wb.adr[ADR_W-1:0]) & ~32'h3;
    assign mapped   = (off <= ADR_LAST);
    // No new request while a response is on the bus: a held strobe gets one
    // response every other cycle.
    assign req      = wb.cyc & wb.stb & ~(ack_q | err_q);
    assign wr_en    = req & wb.we & mapped;
    assign mii_busy = mii_status_i[1];

    // Current register image; also the base for byte-lane write merging, so
    // unimplemented bits never pick up written data.
    always_comb begin
        rd_data = '0;
        case (off)
            ADR_MODER:      rd_data = {15'b0, moder_q};
            ADR_INT_SOURCE: rd_data = {25'b0, int_src};
            ADR_INT_MASK:   rd_data = {25'b0, int_mask};
            ADR_IPGT:       rd_data = {25'b0, ipgt_q};
            ADR_IPGR1:      rd_data = {25'b0, ipgr1_q};
            ADR_IPGR2:      rd_data = {25'b0, ipgr2_q};
            ADR_PACKETLEN:  rd_data = packetlen_q;
            ADR_COLLCONF:   rd_data = {10'b0, coll_max_q, 10'b0, coll_valid_q};
            ADR_TX_BD_NUM:  rd_data = {24'b0, tx_bd_num_q};
            ADR_CTRLMODER:  rd_data = {29'b0, ctrlmoder_q};
            ADR_MIIMODER:   rd_data = {23'b0, miimoder_q};
            ADR_MIICOMMAND: rd_data = {31'b0, scanstat_q};
            ADR_MIIADDRESS: rd_data = {19'b0, rgad_q, 3'b0, fiad_q};
            ADR_MIITX_DATA: rd_data = {16'b0, miitx_q};
            ADR_MIIRX_DATA: rd_data = {16'b0, mii_rx_data_i};
            ADR_MIISTATUS:  rd_data = {29'b0, mii_status_i};
            ADR_MAC_ADDR0:  rd_data = mac0_q;
            ADR_MAC_ADDR1:  rd_data = {16'b0, mac1_q};
            ADR_HASH0:      rd_data = hash0_q;
            ADR_HASH1:      rd_data = hash1_q;
            ADR_TXCTRL:     rd_data = {15'b0, txctrl_q};
            default:        rd_data = '0;
        endcase
    end

    assign wv = byte_wr(rd_data, wb.wdat, wb.sel);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            moder_q      <= MODER_RST;
            ipgt_q       <= IPGT_RST;
            ipgr1_q      <= IPGR1_RST;
            ipgr2_q      <= IPGR2_RST;
            packetlen_q  <= PACKETLEN_RST;
            coll_max_q   <= COLL_MAX_RST;
            coll_valid_q <= COLL_VALID_RST;
            tx_bd_num_q  <= TX_BD_NUM_RST;
            ctrlmoder_q  <= '0;
            miimoder_q   <= MIIMODER_RST;
            scanstat_q   <= 1'b0;
            rgad_q       <= '0;
            fiad_q       <= '0;
            miitx_q      <= '0;
            mac0_q       <= '0;
            mac1_q       <= '0;
            hash0_q      <= '0;
            hash1_q      <= '0;
            txctrl_q     <= '0;
        end else if (wr_en) begin
            case (off)
                ADR_MODER:      moder_q     <= wv[16:0];
                ADR_IPGT:       ipgt_q      <= wv[6:0];
                ADR_IPGR1:      ipgr1_q     <= wv[6:0];
                ADR_IPGR2:      ipgr2_q     <= wv[6:0];
                ADR_PACKETLEN:  packetlen_q <= wv;
                ADR_COLLCONF: begin
                    coll_max_q   <= wv[21:16];
                    coll_valid_q <= wv[5:0];
                end
                // Out-of-range descriptor counts are acked but dropped.
                ADR_TX_BD_NUM:  if (wv[7:0] <= TX_BD_MAX) tx_bd_num_q <= wv[7:0];
                ADR_CTRLMODER:  ctrlmoder_q <= wv[2:0];
                ADR_MIIMODER:   miimoder_q  <= wv[8:0];
                ADR_MIICOMMAND: if (!mii_busy && wb.sel[0]) scanstat_q <= wb.wdat[0];
                ADR_MIIADDRESS: begin
                    rgad_q <= wv[12:8];
                    fiad_q <= wv[4:0];
                end
                ADR_MIITX_DATA: miitx_q  <= wv[15:0];
                ADR_MAC_ADDR0:  mac0_q   <= wv;
                ADR_MAC_ADDR1:  mac1_q   <= wv[15:0];
                ADR_HASH0:      hash0_q  <= wv;
                ADR_HASH1:      hash1_q  <= wv;
                ADR_TXCTRL:     txctrl_q <= wv[16:0];
                default: ;  // INT_* live in eth_irq_ctrl; MIIRX/MIISTATUS are read-only
            endcase
        end
    end

    // Response path: one-cycle ack/err, read data only alongside a read ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdat_q    <= '0;
            mii_cmd_q <= '0;
        end else begin
            ack_q     <= req & mapped;
            err_q     <= req & ~mapped;
            rdat_q    <= (req && mapped && !wb.we) ? rd_data : '0;
            // Command bits come from the raw write data, not the merged word,
            // so a stored scanstat never re-fires on an unrelated write.
            mii_cmd_q <= (wr_en && off == ADR_MIICOMMAND && !mii_busy)
                         ? (wb.wdat[2:0] & {3{wb.sel[0]}}) : 3'b000;
        end
    end

    eth_irq_ctrl u_irq (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_ni),
        .event_i   (irq_event_i),
        .src_wr_i  (wr_en && off == ADR_INT_SOURCE && wb.sel[0]),
        .mask_wr_i (wr_en && off == ADR_INT_MASK && wb.sel[0]),
        .wdat_i    (wb.wdat[6:0]),
        .src_o     (int_src),
        .mask_o    (int_mask),
        .int_o     (int_o)
    );

    assign wb.ack      = ack_q;
    assign wb.err      = err_q;
    assign wb.rdat     = rdat_q;
    assign mii_cmd_o   = mii_cmd_q;
    assign moder_o     = moder_q;
    assign tx_bd_num_o = tx_bd_num_q;
    assign mac_addr_o  = {mac1_q, mac0_q};
    assign ipgt_o      = ipgt_q;
    assign packetlen_o = packetlen_q;
    assign collconf_o  = {10'b0, coll_max_q, 10'b0, coll_valid_q};

endmodule
